// File: rtl/nrzi_pkg.sv
// nrzi_pkg: shared types and defaults for the NRZI receive path.
//   rx_state_t             - receiver FSM states (HUNT for sync, RECV for data)
//   NRZI_SYNC_DEFAULT      - default sync window pattern, newest decoded bit in bit 7
//   NRZI_STUFF_LEN_DEFAULT - default run of decoded 1s that forces a stuffed 0
package nrzi_pkg;

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        RECV = 1'b1
    } rx_state_t;

    // Seven 0s then a single 1 in time order.
    localparam logic [7:0]  NRZI_SYNC_DEFAULT      = 8'h80;
    localparam int unsigned NRZI_STUFF_LEN_DEFAULT = 6;

endpackage

// File: rtl/nrzi_bit_decoder.sv
// nrzi_bit_decoder: turns the NRZI line level into decoded data bits.
// A held level decodes as 1, a transition decodes as 0. This undoes the encoder,
// whose line toggles on a 0 and holds on a 1.
//   clock_i   - sample clock, one bit cell per rising edge
//   reset_i   - asynchronous active-high reset; previous level returns to 1
//   line_i    - raw NRZI line level
//   dec_bit_o - combinational decoded bit for the current cell
module nrzi_bit_decoder (
    input  logic clock_i,
    input  logic reset_i,
    input  logic line_i,
    output logic dec_bit_o
);

    logic prev_q;

    // The previous level tracks the line in every state and even during a
    // synchronous abort, so the first bit after an abort still decodes right.
    // Reset value 1 matches the encoder's idle line level.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= line_i;
        end
    end

    assign dec_bit_o = ~(line_i ^ prev_q);

endmodule

// File: rtl/nrzi_rx.sv
// nrzi_rx: NRZI serial receiver. Decodes the line, hunts for the sync
// pattern, strips stuffed 0s and assembles LSB-first bytes.
//   clock       - single clock, one line sample per rising edge
//   reset       - asynchronous active-high reset
//   line        - NRZI line level
//   clear       - synchronous abort back to HUNT, suppresses any pulse this cycle
//   data_out    - last completed byte, first received bit in bit 0
//   data_valid  - one-cycle pulse when data_out updates
//   sync_found  - one-cycle pulse when the sync pattern is matched
//   stuff_error - one-cycle pulse when a run of 1s is not followed by a stuffed 0
module nrzi_rx
    import nrzi_pkg::*;
#(
    parameter logic [7:0]  SYNC      = NRZI_SYNC_DEFAULT,
    parameter int unsigned STUFF_LEN = NRZI_STUFF_LEN_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       line,
    input  logic       clear,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       sync_found,
    output logic       stuff_error
);

    localparam int unsigned       OnesW    = $clog2(STUFF_LEN + 1);
    localparam logic [OnesW-1:0]  StuffMax = OnesW'(STUFF_LEN);
    localparam logic [OnesW-1:0]  OnesOne  = OnesW'(1);

    logic dec_bit;

    nrzi_bit_decoder u_dec (
        .clock_i   (clock),
        .reset_i   (reset),
        .line_i    (line),
        .dec_bit_o (dec_bit)
    );

    rx_state_t        state_q,       state_d;
    logic [7:0]       window_q,      window_d;
    logic [7:0]       shreg_q,       shreg_d;
    logic [OnesW-1:0] ones_q,        ones_d;
    logic [2:0]       bit_cnt_q,     bit_cnt_d;
    logic [7:0]       data_out_q,    data_out_d;
    logic             data_valid_q,  data_valid_d;
    logic             sync_found_q,  sync_found_d;
    logic             stuff_error_q, stuff_error_d;

    // Right shift with the new bit entering at the top. Written as shift-or so
    // every bit of the source register is consumed.
    logic [7:0] win_shift;
    logic [7:0] sh_shift;

    always_comb begin
        win_shift = {dec_bit, 7'b0} | (window_q >> 1);
        sh_shift  = {dec_bit, 7'b0} | (shreg_q >> 1);
    end

    always_comb begin
        state_d       = state_q;
        window_d      = window_q;
        shreg_d       = shreg_q;
        ones_d        = ones_q;
        bit_cnt_d     = bit_cnt_q;
        data_out_d    = data_out_q;
        data_valid_d  = 1'b0;
        sync_found_d  = 1'b0;
        stuff_error_d = 1'b0;

        if (clear) begin
            // Abort wins over any match, byte or error in the same cycle.
            state_d   = HUNT;
            window_d  = '0;
            shreg_d   = '0;
            ones_d    = '0;
            bit_cnt_d = '0;
        end else begin
            unique case (state_q)
                HUNT: begin
                    window_d = win_shift;
                    if (win_shift == SYNC) begin
                        state_d      = RECV;
                        sync_found_d = 1'b1;
                        ones_d       = '0;
                        bit_cnt_d    = '0;
                    end
                end

                RECV: begin
                    if (ones_q == StuffMax) begin
                        // This cell must be a stuffed 0. It is dropped without
                        // touching the byte, even across a byte boundary.
                        if (dec_bit) begin
                            stuff_error_d = 1'b1;
                            state_d       = HUNT;
                            window_d      = '0;
                            shreg_d       = '0;
                            ones_d        = '0;
                            bit_cnt_d     = '0;
                        end else begin
                            ones_d = '0;
                        end
                    end else begin
                        shreg_d = sh_shift;
                        ones_d  = dec_bit ? (ones_q + OnesOne) : '0;
                        if (bit_cnt_q == 3'd7) begin
                            data_out_d   = sh_shift;
                            data_valid_d = 1'b1;
                            bit_cnt_d    = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end

                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= HUNT;
            window_q      <= '0;
            shreg_q       <= '0;
            ones_q        <= '0;
            bit_cnt_q     <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            sync_found_q  <= 1'b0;
            stuff_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            window_q      <= window_d;
            shreg_q       <= shreg_d;
            ones_q        <= ones_d;
            bit_cnt_q     <= bit_cnt_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            sync_found_q  <= sync_found_d;
            stuff_error_q <= stuff_error_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign sync_found  = sync_found_q;
    assign stuff_error = stuff_error_q;

endmodule

// File: tb/tb_nrzi_rx.sv
// tb_nrzi_rx: self-checking bench for nrzi_rx. Stimulus is written as decoded
// bits and NRZI-encoded here; expected pulses go into a queue that a monitor
// drains as the DUT produces them.
module tb_nrzi_rx;

    localparam logic [1:0] EvSync = 2'd0;
    localparam logic [1:0] EvByte = 2'd1;
    localparam logic [1:0] EvErr  = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } ev_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       line;
    logic       clear;
    logic [7:0] data_out;
    logic       data_valid;
    logic       sync_found;
    logic       stuff_error;

    int  n_checks = 0;
    int  n_errors = 0;
    ev_t exp_q[$];
    logic enc_lvl;

    nrzi_rx dut (
        .clock       (clock),
        .reset       (reset),
        .line        (line),
        .clear       (clear),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .sync_found  (sync_found),
        .stuff_error (stuff_error)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every pulse must match the next queued expectation.
    always @(negedge clock) begin
        ev_t        e;
        logic [1:0] kind;
        if (sync_found || data_valid || stuff_error) begin
            check_eq("one_pulse", 32'(sync_found) + 32'(data_valid) + 32'(stuff_error), 32'd1);
            kind = sync_found ? EvSync : (data_valid ? EvByte : EvErr);
            if (exp_q.size() == 0) begin
                check_eq("spurious_pulse", {29'b0, sync_found, data_valid, stuff_error}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("pulse_kind", 32'(kind), 32'(e.kind));
                if (e.kind == EvByte) check_eq("byte_data", 32'(data_out), 32'(e.data));
            end
        end
    end

    // Drive one decoded bit as an NRZI cell: hold for 1, toggle for 0.
    task automatic send_bit(input logic d, input logic clr);
        line    = d ? enc_lvl : ~enc_lvl;
        enc_lvl = line;
        clear   = clr;
        @(negedge clock);
        clear   = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        logic [15:0] b;
        b = bits;
        for (int i = 0; i < n; i++) send_bit(b[i], 1'b0);
    endtask

    task automatic expect_ev(input logic [1:0] kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic send_sync();
        expect_ev(EvSync, 8'h00);
        send_bits(16'h0080, 8);
    endtask

    task automatic start_frame();
        send_bit(1'b0, 1'b1);
        send_sync();
    endtask

    task automatic drained(input string tag);
        #1;
        check_eq(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    initial begin
        reset   = 1'b0;
        line    = 1'b1;
        clear   = 1'b0;
        enc_lvl = 1'b1;
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        check_eq("rst_data_out", 32'(data_out), 32'h00);
        check_eq("rst_data_valid", 32'(data_valid), 32'd0);
        check_eq("rst_sync_found", 32'(sync_found), 32'd0);
        check_eq("rst_stuff_error", 32'(stuff_error), 32'd0);
        reset = 1'b0;

        // Sync then byte A5: line 0,1,0,1,0,1,0,0 then 0,1,1,0,1,1,0,0.
        send_sync();
        drained("sync_first");
        expect_ev(EvByte, 8'hA5);
        send_bits(16'h00A5, 8);
        drained("byte_a5");
        send_bits(16'h0000, 2);
        check_eq("data_out_hold", 32'(data_out), 32'hA5);

        // FF with a stuffed 0 after six 1s.
        start_frame();
        expect_ev(EvByte, 8'hFF);
        send_bits(16'b1_1011_1111, 9);
        drained("byte_ff_stuffed");
        // Run continues from two 1s: stuffed 0 lands inside the next byte.
        expect_ev(EvByte, 8'h8F);
        send_bits(16'b1_0000_1111, 9);
        drained("byte_8f_stuff_mid");
        // Byte ends on six 1s; the stuffed 0 must not become bit 0 of 00.
        expect_ev(EvByte, 8'hFC);
        expect_ev(EvByte, 8'h00);
        send_bits(16'hFC, 8);
        send_bits(16'h0000, 9);
        drained("stuff_across_bytes");

        // Seven 1s: error on the 7th, then a sync proves the return to HUNT.
        start_frame();
        send_bits(16'h003F, 6);
        expect_ev(EvErr, 8'h00);
        send_bit(1'b1, 1'b0);
        drained("stuff_violation");
        send_sync();
        drained("hunt_after_error");

        // Decoded zeros never sync.
        send_bit(1'b0, 1'b1);
        send_bits(16'h0000, 16);
        drained("no_sync_zeros");

        // Clear mid-byte, then a fresh frame with 3C.
        start_frame();
        send_bits(16'b1101, 4);
        send_bit(1'b0, 1'b1);
        send_bits(16'h0000, 4);
        drained("clear_mid_byte");
        send_sync();
        expect_ev(EvByte, 8'h3C);
        send_bits(16'h003C, 8);
        drained("byte_3c");
        check_eq("data_out_3c", 32'(data_out), 32'h3C);

        // Clear coinciding with sync match, byte completion and stuff error.
        send_bit(1'b0, 1'b1);
        send_bits(16'h0000, 7);
        send_bit(1'b1, 1'b1);
        drained("clear_vs_sync");
        start_frame();
        send_bits(16'h0055, 7);
        send_bit(1'b0, 1'b1);
        drained("clear_vs_byte");
        start_frame();
        send_bits(16'h003F, 6);
        send_bit(1'b1, 1'b1);
        drained("clear_vs_stuff_err");

        // Asynchronous reset between edges after 5 data bits.
        start_frame();
        expect_ev(EvByte, 8'hA5);
        send_bits(16'h00A5, 8);
        drained("byte_a5_pre_reset");
        send_bits(16'b10110, 5);
        #2 reset = 1'b1;
        #1;
        check_eq("async_rst_data_out", 32'(data_out), 32'h00);
        check_eq("async_rst_valid", 32'(data_valid), 32'd0);
        check_eq("async_rst_sync", 32'(sync_found), 32'd0);
        check_eq("async_rst_err", 32'(stuff_error), 32'd0);
        check_eq("async_rst_prev_line", 32'(dut.u_dec.prev_q), 32'd1);
        @(negedge clock);
        reset   = 1'b0;
        enc_lvl = 1'b1;
        send_sync();
        expect_ev(EvByte, 8'hA5);
        send_bits(16'h00A5, 8);
        drained("byte_a5_post_reset");
        check_eq("data_out_post_reset", 32'(data_out), 32'hA5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
